// File: rtl/xbar_port_deser.sv
// Serial-to-parallel receiver for one crossbar output line.
// A frame is an 8-bit header (bit 7 always 1, which doubles as the start
// bit) followed by an 8-bit payload, both MSB-first and sampled only on
// cycles where bit_en is high. Completed frames go into a one-deep holding
// register with a valid/ready handshake. A frame that completes while the
// holding register is full and not being drained is dropped.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bit_en          bit strobe; serial_in is sampled only when high
//   serial_in       serial line, MSB-first
//   out_ready       downstream accepts the held frame
//   out_valid       holding register contains a frame
//   out_hdr/out_pay held header / payload
//   out_par_err     held header has even overall parity
//   out_fmt_err     held header has reserved bit [1] set
//   overflow        one-cycle pulse when a completed frame is dropped
//   frame_cnt       frames loaded, wrapping
//   err_cnt         loaded frames with any header error, saturating
module xbar_port_deser #(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_en,
  input  logic                   serial_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_hdr,
  output logic [7:0]             out_pay,
  output logic                   out_par_err,
  output logic                   out_fmt_err,
  output logic                   overflow,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             hdr_sh_q, hdr_sh_d;
  logic [7:0]             pay_sh_q, pay_sh_d;
  logic                   valid_q, valid_d;
  logic [7:0]             hdr_q, hdr_d;
  logic [7:0]             pay_q, pay_d;
  logic                   par_err_q, par_err_d;
  logic                   fmt_err_q, fmt_err_d;
  logic                   ovf_q, ovf_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic complete;
  logic load;
  logic new_par_err;
  logic new_fmt_err;

  // Receive FSM: header and payload shift registers, bit counter.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hdr_sh_d  = hdr_sh_q;
    pay_sh_d  = pay_sh_q;
    complete  = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (serial_in) begin
            hdr_sh_d  = 8'h01;
            bit_cnt_d = 3'd1;
            state_d   = StHdr;
          end
        end
        StHdr: begin
          hdr_sh_d = {hdr_sh_q[6:0], serial_in};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = StPay;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StPay: begin
          pay_sh_d = {pay_sh_q[6:0], serial_in};
          if (bit_cnt_q == 3'd7) begin
            complete  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Header is fully shifted in by the time any payload bit completes a frame.
  assign new_par_err = ~^hdr_sh_q;
  assign new_fmt_err = hdr_sh_q[1];

  // Holding register: accept when empty or being drained on the same edge.
  assign load = complete && (!valid_q || out_ready);

  always_comb begin
    valid_d     = valid_q;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    par_err_d   = par_err_q;
    fmt_err_d   = fmt_err_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovf_d       = complete && valid_q && !out_ready;
    if (load) begin
      valid_d     = 1'b1;
      hdr_d       = hdr_sh_q;
      pay_d       = {pay_sh_q[6:0], serial_in};
      par_err_d   = new_par_err;
      fmt_err_d   = new_fmt_err;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      if ((new_par_err || new_fmt_err) && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      hdr_sh_q    <= 8'h00;
      pay_sh_q    <= 8'h00;
      valid_q     <= 1'b0;
      hdr_q       <= 8'h00;
      pay_q       <= 8'h00;
      par_err_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_sh_q    <= hdr_sh_d;
      pay_sh_q    <= pay_sh_d;
      valid_q     <= valid_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      par_err_q   <= par_err_d;
      fmt_err_q   <= fmt_err_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_hdr     = hdr_q;
  assign out_pay     = pay_q;
  assign out_par_err = par_err_q;
  assign out_fmt_err = fmt_err_q;
  assign overflow    = ovf_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_xbar_port_deser.sv
module tb_xbar_port_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        serial_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_hdr;
  logic [7:0]  out_pay;
  logic        out_par_err;
  logic        out_fmt_err;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  xbar_port_deser #(
    .FRAME_CNT_W(16),
    .ERR_CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_hdr    (out_hdr),
    .out_pay    (out_pay),
    .out_par_err(out_par_err),
    .out_fmt_err(out_fmt_err),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ovf_seen = 0;
  logic rand_ready = 1'b0;

  // Reference model: the one-deep holding register seen as a mailbox.
  logic       m_valid;
  logic [7:0] m_hdr, m_pay;
  logic       m_par, m_fmt, exp_ovf;
  int         m_fc, m_ec;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] pay;
    logic       par;
    logic       fmt;
  } vec_t;
  vec_t vecs[6];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    logic [15:0] efc;
    logic [7:0]  eec;
    efc = m_fc[15:0];
    eec = (m_ec > 255) ? 8'hFF : m_ec[7:0];
    cmp(name,
        {20'd0, out_valid, out_hdr, out_pay, out_par_err, out_fmt_err, overflow, frame_cnt,
         err_cnt},
        {20'd0, m_valid, m_hdr, m_pay, m_par, m_fmt, exp_ovf, efc, eec});
  endtask

  task automatic model_clear();
    m_valid = 0; m_hdr = 0; m_pay = 0; m_par = 0; m_fmt = 0; exp_ovf = 0;
    m_fc = 0; m_ec = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic be, input logic sin, input logic comp,
                      input logic [7:0] h, input logic [7:0] p, input logic rdy);
    bit_en    = be;
    serial_in = sin;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : rdy;
    @(posedge clk);
    exp_ovf = 1'b0;
    if (comp) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_hdr = h; m_pay = p; m_par = ~^h; m_fmt = h[1];
        m_fc++;
        if (m_par || m_fmt) m_ec++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_state("cycle");
    if (overflow) ovf_seen++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00, rdy);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] p, input int gap,
                            input logic r_rest, input logic r_last);
    logic [15:0] bits;
    bits = {h, p};
    for (int i = 15; i >= 0; i--) begin
      tick(1'b1, bits[i], i == 0, h, p, (i == 0) ? r_last : r_rest);
      if (i != 0) idle(gap, r_rest);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_en = 1'b0;
    #1;
    model_clear();
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hB9, 8'h03, 1'b0, 1'b0};
    vecs[1] = '{8'hB8, 8'h05, 1'b1, 1'b0};
    vecs[2] = '{8'h83, 8'hAA, 1'b0, 1'b1};
    vecs[3] = '{8'hC6, 8'h55, 1'b1, 1'b1};
    vecs[4] = '{8'hF1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h00, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    cmp("reset_valid", 64'(out_valid), 64'd0);
    cmp("reset_cnt", 64'({frame_cnt, err_cnt}), 64'd0);

    // Table: frames with ready held high, checked right after the final bit edge.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].hdr, vecs[i].pay, 2, 1'b1, 1'b1);
      cmp("tbl_valid", 64'(out_valid), 64'd1);
      cmp("tbl_data", 64'({out_hdr, out_pay}), 64'({vecs[i].hdr, vecs[i].pay}));
      cmp("tbl_err", 64'({out_par_err, out_fmt_err}), 64'({vecs[i].par, vecs[i].fmt}));
      cmp("tbl_fcnt", 64'(frame_cnt), 64'(i + 1));
      idle(3, 1'b1);
      cmp("tbl_drained", 64'(out_valid), 64'd0);
    end
    cmp("tbl_ecnt", 64'(err_cnt), 64'd3);

    // Overflow: second frame dropped while the first is held.
    do_reset();
    ovf_seen = 0;
    send_frame(8'h80, 8'h00, 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_frame(8'hB9, 8'h03, 1, 1'b0, 1'b0);
    idle(3, 1'b0);
    cmp("ovf_pulses", 64'(ovf_seen), 64'd1);
    cmp("ovf_hdr", 64'({out_valid, out_hdr}), 64'({1'b1, 8'h80}));
    cmp("ovf_fcnt", 64'(frame_cnt), 64'd1);
    idle(1, 1'b1);
    cmp("ovf_drain", 64'(out_valid), 64'd0);

    // Reset after five header bits discards the partial frame.
    do_reset();
    for (int i = 7; i >= 3; i--) tick(1'b1, vecs[0].hdr[i], 1'b0, 8'h00, 8'h00, 1'b1);
    do_reset();
    send_frame(8'h80, 8'h07, 0, 1'b1, 1'b1);
    cmp("rst_mid_data", 64'({out_valid, out_hdr, out_pay}), 64'({1'b1, 8'h80, 8'h07}));
    cmp("rst_mid_fcnt", 64'(frame_cnt), 64'd1);

    // Completion coinciding with acceptance: valid stays up, new data, no overflow.
    do_reset();
    ovf_seen = 0;
    send_frame(8'h90, 8'h11, 0, 1'b0, 1'b0);
    send_frame(8'hA1, 8'h22, 0, 1'b0, 1'b1);
    cmp("b2b_data", 64'({out_valid, out_hdr, out_pay}), 64'({1'b1, 8'hA1, 8'h22}));
    cmp("b2b_ovf", 64'(ovf_seen), 64'd0);
    cmp("b2b_fcnt", 64'(frame_cnt), 64'd2);
    idle(1, 1'b1);

    // Saturation of the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) send_frame(8'h81, 8'(i), 0, 1'b1, 1'b1);
    cmp("sat_fcnt", 64'(frame_cnt), 64'd300);
    cmp("sat_ecnt", 64'(err_cnt), 64'hFF);

    // Random frames, random ready, random strobe spacing and leading zeros.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] h, p;
      h = {1'b1, 7'($urandom)};
      p = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      send_frame(h, p, $urandom_range(0, 2), 1'b0, 1'b0);
      idle($urandom_range(0, 3), 1'b0);
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
